// File: rtl/mem_to_banks_sparse.sv
// mem_to_banks_sparse: splits a wide request into per-bank requests, issuing only
// to banks with a non-zero strobe slice, and reassembles responses in order.
//
// Handshakes: a transfer happens on any interface in a cycle where valid and
// ready (req_i/gnt_o, bank_req_o/bank_gnt_i) are both high; valid never depends
// on ready. rvalid_o and bank_rvalid_i carry no backpressure.

// Small FIFO used for the per-bank request, per-bank response and tracking queues.
// With FallThrough set, a push into an empty FIFO is visible on data_o in the
// same cycle and may be popped immediately without ever being stored.
module mem_to_banks_sparse_fifo #(
  parameter int unsigned Width       = 8,
  parameter int unsigned Depth       = 2,
  parameter bit          FallThrough = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             stored_empty;
  logic             bypass;
  logic             do_write;
  logic             do_read;

  assign stored_empty = (cnt_q == '0);
  assign bypass       = FallThrough && stored_empty && push_i && pop_i;
  assign do_write     = push_i && !bypass;
  assign do_read      = pop_i && !stored_empty;
  assign full_o       = (cnt_q == CntW'(Depth));
  assign empty_o      = stored_empty && !(FallThrough && push_i);
  assign data_o       = (FallThrough && stored_empty) ? data_i : mem_q[rptr_q];

  // Next storage contents, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_write) begin
      mem_d[wptr_q] = data_i;
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (do_read) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
    end
    case ({do_write, do_read})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers; reset empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(Depth); k++) mem_q[k] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module mem_to_banks_sparse #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned WUserWidth  = 1,
  parameter int unsigned RUserWidth  = 1,
  parameter int unsigned NumBanks    = 2,
  parameter int unsigned MaxTrans    = 4,
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned CompactAddr = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               req_i,
  output logic                               gnt_o,
  input  logic [AddrWidth-1:0]               addr_i,
  input  logic [DataWidth-1:0]               wdata_i,
  input  logic [DataWidth/8-1:0]             strb_i,
  input  logic [WUserWidth-1:0]              wuser_i,
  input  logic                               we_i,
  output logic                               rvalid_o,
  output logic [DataWidth-1:0]               rdata_o,
  output logic [NumBanks*RUserWidth-1:0]     ruser_o,
  output logic [NumBanks-1:0]                rmask_o,
  output logic [$clog2(MaxTrans+1)-1:0]      outstanding_o,
  output logic [NumBanks-1:0]                bank_req_o,
  input  logic [NumBanks-1:0]                bank_gnt_i,
  output logic [NumBanks*AddrWidth-1:0]      bank_addr_o,
  output logic [DataWidth-1:0]               bank_wdata_o,
  output logic [DataWidth/8-1:0]             bank_strb_o,
  output logic [NumBanks*WUserWidth-1:0]     bank_wuser_o,
  output logic [NumBanks-1:0]                bank_we_o,
  input  logic [NumBanks-1:0]                bank_rvalid_i,
  input  logic [DataWidth-1:0]               bank_rdata_i,
  input  logic [NumBanks*RUserWidth-1:0]     bank_ruser_i
);
  localparam int unsigned DataBytes = DataWidth / 8;
  localparam int unsigned BankDW    = DataWidth / NumBanks;
  localparam int unsigned BankBytes = BankDW / 8;
  localparam int unsigned OffW      = $clog2(DataBytes);
  localparam int unsigned BankOffW  = $clog2(BankBytes);
  localparam int unsigned OutW      = $clog2(MaxTrans + 1);
  localparam int unsigned ReqW      = AddrWidth + BankDW + BankBytes + WUserWidth + 1;
  localparam int unsigned RspW      = BankDW + RUserWidth;

  logic [NumBanks-1:0]  act;
  logic [NumBanks-1:0]  req_full;
  logic [NumBanks-1:0]  req_empty;
  logic [NumBanks-1:0]  rsp_empty;
  logic [NumBanks-1:0]  rsp_full;
  logic [NumBanks-1:0]  rsp_pop;
  logic [NumBanks-1:0]  trk_head;
  logic                 trk_empty;
  logic                 trk_full;
  logic                 accept;
  logic [OutW-1:0]      outstanding_q, outstanding_d;
  logic [AddrWidth-1:0] addr_aligned;
  logic [AddrWidth-1:0] addr_compact;

  // Base addresses: aligned wide address, or the bank-local word index scaled to
  // bank bytes when banks are addressed in their own compact space.
  assign addr_aligned = addr_i & ~AddrWidth'(DataBytes - 1);
  assign addr_compact = (addr_i >> OffW) << BankOffW;

  assign accept        = req_i && gnt_o;
  assign rmask_o       = rvalid_o ? trk_head : '0;
  assign outstanding_o = outstanding_q;

  for (genvar i = 0; i < int'(NumBanks); i++) begin : g_bank
    logic [AddrWidth-1:0] push_addr;
    logic [ReqW-1:0]      req_in;
    logic [ReqW-1:0]      req_out;
    logic [RspW-1:0]      rsp_in;
    logic [RspW-1:0]      rsp_out;

    assign act[i]     = |strb_i[i*BankBytes +: BankBytes];
    assign push_addr  = (CompactAddr != 0) ? addr_compact
                                           : addr_aligned + AddrWidth'(i * BankBytes);
    assign req_in     = {push_addr, wdata_i[i*BankDW +: BankDW],
                         strb_i[i*BankBytes +: BankBytes], wuser_i, we_i};

    mem_to_banks_sparse_fifo #(
      .Width(ReqW), .Depth(FifoDepth), .FallThrough(1'b1)
    ) u_req_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (accept && act[i]),
      .data_i  (req_in),
      .pop_i   (bank_req_o[i] && bank_gnt_i[i]),
      .data_o  (req_out),
      .empty_o (req_empty[i]),
      .full_o  (req_full[i])
    );

    assign bank_req_o[i] = !req_empty[i];
    assign {bank_addr_o[i*AddrWidth +: AddrWidth], bank_wdata_o[i*BankDW +: BankDW],
            bank_strb_o[i*BankBytes +: BankBytes], bank_wuser_o[i*WUserWidth +: WUserWidth],
            bank_we_o[i]} = req_out;

    // The outstanding limit keeps this FIFO from filling; the full gate only
    // protects its pointers if a bank ever misbehaves.
    assign rsp_in = {bank_ruser_i[i*RUserWidth +: RUserWidth], bank_rdata_i[i*BankDW +: BankDW]};

    mem_to_banks_sparse_fifo #(
      .Width(RspW), .Depth(MaxTrans), .FallThrough(1'b0)
    ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (bank_rvalid_i[i] && !rsp_full[i]),
      .data_i  (rsp_in),
      .pop_i   (rsp_pop[i]),
      .data_o  (rsp_out),
      .empty_o (rsp_empty[i]),
      .full_o  (rsp_full[i])
    );

    assign rsp_pop[i] = rvalid_o && trk_head[i];
    assign rdata_o[i*BankDW +: BankDW] = rsp_pop[i] ? rsp_out[BankDW-1:0] : '0;
    assign ruser_o[i*RUserWidth +: RUserWidth] =
      rsp_pop[i] ? rsp_out[RspW-1 -: RUserWidth] : '0;
  end

  // Records which banks each accepted transaction used, in acceptance order.
  mem_to_banks_sparse_fifo #(
    .Width(NumBanks), .Depth(MaxTrans), .FallThrough(1'b0)
  ) u_trk_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (act),
    .pop_i   (rvalid_o),
    .data_o  (trk_head),
    .empty_o (trk_empty),
    .full_o  (trk_full)
  );

  // Grant only needs room in the queues of the banks this request touches.
  always_comb begin
    gnt_o = !rst_i && (outstanding_q < OutW'(MaxTrans)) && !trk_full;
    for (int k = 0; k < int'(NumBanks); k++) begin
      if (act[k] && req_full[k]) gnt_o = 1'b0;
    end
  end

  // Head transaction completes once every bank it used has a response queued.
  always_comb begin
    rvalid_o = !trk_empty;
    for (int k = 0; k < int'(NumBanks); k++) begin
      if (trk_head[k] && rsp_empty[k]) rvalid_o = 1'b0;
    end
  end

  // Outstanding count: accept adds one, response removes one.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !rvalid_o)      outstanding_d = outstanding_q + 1'b1;
    else if (!accept && rvalid_o) outstanding_d = outstanding_q - 1'b1;
  end

  // Outstanding counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) outstanding_q <= '0;
    else       outstanding_q <= outstanding_d;
  end
endmodule

// File: tb/tb_mem_to_banks_sparse.sv
// Bench for mem_to_banks_sparse: 128-bit data, 4 banks, MaxTrans 4. A second
// instance with compact addressing shares all inputs; its state tracks the first
// one, so both are held to the same transaction-level reference model.
module tb_mem_to_banks_sparse;
  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int NB  = 4;
  localparam int MT  = 4;
  localparam int FD  = 2;
  localparam int BDW = DW / NB;
  localparam int OW  = $clog2(MT + 1);
  localparam int EW  = NB + NB + DW;  // expected response {rmask, ruser, rdata}
  localparam int QW  = 102;           // expected bank request {addr, caddr, wdata, strb, wuser, we}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic            req_i = 1'b0, we_i = 1'b0;
  logic [AW-1:0]   addr_i = '0;
  logic [DW-1:0]   wdata_i = '0;
  logic [DW/8-1:0] strb_i = '0;
  logic [0:0]      wuser_i = '0;
  logic [NB-1:0]   bank_gnt_i = '0, bank_rvalid_i = '0;
  logic [DW-1:0]   bank_rdata_i = '0;
  logic [NB-1:0]   bank_ruser_i = '0;

  logic gnt_o, rvalid_o, c_gnt_o, c_rvalid_o;
  logic [DW-1:0] rdata_o, c_rdata_o, bank_wdata_o, c_bank_wdata_o;
  logic [NB-1:0] ruser_o, rmask_o, bank_req_o, bank_wuser_o, bank_we_o;
  logic [NB-1:0] c_ruser_o, c_rmask_o, c_bank_req_o, c_bank_wuser_o, c_bank_we_o;
  logic [OW-1:0] outstanding_o, c_outstanding_o;
  logic [NB*AW-1:0] bank_addr_o, c_bank_addr_o;
  logic [DW/8-1:0] bank_strb_o, c_bank_strb_o;

  mem_to_banks_sparse #(
    .AddrWidth(AW), .DataWidth(DW), .WUserWidth(1), .RUserWidth(1),
    .NumBanks(NB), .MaxTrans(MT), .FifoDepth(FD), .CompactAddr(0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .wuser_i(wuser_i), .we_i(we_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .ruser_o(ruser_o), .rmask_o(rmask_o),
    .outstanding_o(outstanding_o), .bank_req_o(bank_req_o), .bank_gnt_i(bank_gnt_i),
    .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o), .bank_strb_o(bank_strb_o),
    .bank_wuser_o(bank_wuser_o), .bank_we_o(bank_we_o), .bank_rvalid_i(bank_rvalid_i),
    .bank_rdata_i(bank_rdata_i), .bank_ruser_i(bank_ruser_i)
  );

  mem_to_banks_sparse #(
    .AddrWidth(AW), .DataWidth(DW), .WUserWidth(1), .RUserWidth(1),
    .NumBanks(NB), .MaxTrans(MT), .FifoDepth(FD), .CompactAddr(1)
  ) dut_c (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(c_gnt_o), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .wuser_i(wuser_i), .we_i(we_i),
    .rvalid_o(c_rvalid_o), .rdata_o(c_rdata_o), .ruser_o(c_ruser_o), .rmask_o(c_rmask_o),
    .outstanding_o(c_outstanding_o), .bank_req_o(c_bank_req_o), .bank_gnt_i(bank_gnt_i),
    .bank_addr_o(c_bank_addr_o), .bank_wdata_o(c_bank_wdata_o), .bank_strb_o(c_bank_strb_o),
    .bank_wuser_o(c_bank_wuser_o), .bank_we_o(c_bank_we_o), .bank_rvalid_i(bank_rvalid_i),
    .bank_rdata_i(bank_rdata_i), .bank_ruser_i(bank_ruser_i)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];          // responses in acceptance order
  int            rem_q[$];          // bank responses still missing per transaction
  int            rdy_q[$];          // earliest cycle the response may appear
  logic [QW-1:0] breq_q[NB][$];     // requests each bank must see, in order
  int            breq_id[NB][$];
  logic [32:0]   brsp_q[NB][$];     // bank responses waiting to be driven {ruser, data}
  int            brsp_id[NB][$];
  int            brsp_due[NB][$];
  logic [7:0]    ref_mem[logic [31:0]];   // wide (byte) view of memory
  logic [31:0]   bank_mem[logic [31:0]];  // bank-side word storage
  int head_id, next_id, cyc;
  int n_checks = 0, n_errors = 0;
  int gnt_pct = 100, lat_max = 1, slow_bank = -1, rsp_en = 1;

  task automatic check(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], 16'h0} ^ {16'hA5C3, ~a[15:0]};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word({a[31:2], 2'b00}) >> (8 * a[1:0]);
    return w[7:0];
  endfunction

  // Accepting a wide request: which banks get what, and what comes back.
  task automatic model_accept(input logic [31:0] a, input logic [15:0] s,
                              input logic [127:0] wd, input logic wu, input logic w);
    logic [31:0]   al;
    logic [DW-1:0] rd;
    logic [NB-1:0] m, ru;
    logic [31:0]   ba;
    int n;
    al = a & ~32'hF;
    rd = '0; m = '0; ru = '0; n = 0;
    for (int i = 0; i < NB; i++) begin
      if (|s[4*i +: 4]) begin
        m[i] = 1'b1; ru[i] = w; n++;
        breq_q[i].push_back({al + 32'(4 * i), (a >> 4) << 2, wd[32*i +: 32], s[4*i +: 4], wu, w});
        breq_id[i].push_back(next_id);
        for (int j = 0; j < 4; j++) begin
          ba = al + 32'(4 * i + j);
          if (w && s[4*i + j]) ref_mem[ba] = wd[8*(4*i + j) +: 8];
          rd[8*(4*i + j) +: 8] = ref_byte(ba);
        end
      end
    end
    exp_q.push_back({m, ru, rd});
    rem_q.push_back(n);
    rdy_q.push_back(cyc + 1);
    next_id++;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic r, input logic [31:0] a, input logic [15:0] s,
                      input logic [127:0] wd, input logic wu, input logic w);
    logic exp_gnt, exp_rv;
    logic [EW-1:0] e;
    logic [QW-1:0] q;
    logic [31:0] word;
    int idx;
    @(negedge clk);
    cyc++;
    req_i = r; addr_i = a; strb_i = s; wdata_i = wd; wuser_i = wu; we_i = w;
    for (int i = 0; i < NB; i++) begin
      bank_gnt_i[i] = ($urandom_range(0, 99) < gnt_pct);
      if (rsp_en != 0 && brsp_q[i].size() > 0 && brsp_due[i][0] <= cyc) begin
        bank_rvalid_i[i] = 1'b1;
        {bank_ruser_i[i], bank_rdata_i[32*i +: 32]} = brsp_q[i].pop_front();
        void'(brsp_due[i].pop_front());
        idx = brsp_id[i].pop_front() - head_id;
        rem_q[idx] = rem_q[idx] - 1;
        if (rdy_q[idx] < cyc + 1) rdy_q[idx] = cyc + 1;
      end else begin
        bank_rvalid_i[i] = 1'b0;
        bank_rdata_i[32*i +: 32] = $urandom;
        bank_ruser_i[i] = 1'($urandom_range(0, 1));
      end
    end
    #1;
    exp_gnt = (exp_q.size() < MT);
    for (int i = 0; i < NB; i++)
      if (|s[4*i +: 4] && breq_q[i].size() >= FD) exp_gnt = 1'b0;
    check("gnt", gnt_o, exp_gnt);
    check("c_gnt", c_gnt_o, exp_gnt);
    check("outstanding", outstanding_o, exp_q.size());
    check("c_outstanding", c_outstanding_o, exp_q.size());
    exp_rv = (exp_q.size() > 0) && (rem_q[0] == 0) && (rdy_q[0] <= cyc);
    check("rvalid", rvalid_o, exp_rv);
    check("c_rvalid", c_rvalid_o, exp_rv);
    if (exp_rv) begin
      e = exp_q.pop_front();
      void'(rem_q.pop_front());
      void'(rdy_q.pop_front());
      head_id++;
      check("rdata", rdata_o, e[DW-1:0]);
      check("c_rdata", c_rdata_o, e[DW-1:0]);
      check("ruser", ruser_o, e[DW+NB-1:DW]);
      check("c_ruser", c_ruser_o, e[DW+NB-1:DW]);
      check("rmask", rmask_o, e[EW-1:DW+NB]);
      check("c_rmask", c_rmask_o, e[EW-1:DW+NB]);
    end else begin
      check("rmask_idle", rmask_o, '0);
      check("c_rmask_idle", c_rmask_o, '0);
    end
    if (r && exp_gnt) model_accept(a, s, wd, wu, w);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("bank%0d_req", i), bank_req_o[i], breq_q[i].size() > 0);
      check($sformatf("c_bank%0d_req", i), c_bank_req_o[i], breq_q[i].size() > 0);
      if (breq_q[i].size() > 0 && bank_gnt_i[i]) begin
        q = breq_q[i].pop_front();
        check($sformatf("bank%0d_fields", i),
              {bank_addr_o[32*i +: 32], bank_wdata_o[32*i +: 32], bank_strb_o[4*i +: 4],
               bank_wuser_o[i], bank_we_o[i]}, {q[101:70], q[37:0]});
        check($sformatf("c_bank%0d_fields", i),
              {c_bank_addr_o[32*i +: 32], c_bank_wdata_o[32*i +: 32], c_bank_strb_o[4*i +: 4],
               c_bank_wuser_o[i], c_bank_we_o[i]}, {q[69:38], q[37:0]});
        word = bank_mem.exists(q[101:70]) ? bank_mem[q[101:70]] : init_word(q[101:70]);
        for (int j = 0; j < 4; j++)
          if (q[0] && q[2 + j]) word[8*j +: 8] = q[6 + 8*j +: 8];
        if (q[0]) bank_mem[q[101:70]] = word;
        brsp_q[i].push_back({q[0], word});
        brsp_id[i].push_back(breq_id[i].pop_front());
        brsp_due[i].push_back(cyc + int'($urandom_range(1, lat_max)) + ((i == slow_bank) ? 6 : 0));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, $urandom, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
  endtask

  task automatic rand_step();
    logic [15:0] s;
    case ($urandom_range(0, 4))
      0: s = 16'h0;
      1: s = 16'hFFFF;
      2: s = 16'($urandom);
      3: s = 16'hF << (4 * $urandom_range(0, 3));
      default: s = 16'($urandom & $urandom);
    endcase
    step(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'($urandom_range(0, 7) * 16) + 32'($urandom_range(0, 15)),
         s, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Asynchronous reset: outputs must drop before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; bank_rvalid_i = '0; bank_gnt_i = '0;
    #1;
    check("rst_gnt", {c_gnt_o, gnt_o}, '0);
    check("rst_rvalid", {c_rvalid_o, rvalid_o}, '0);
    check("rst_bank_req", {c_bank_req_o, bank_req_o}, '0);
    check("rst_rmask", {c_rmask_o, rmask_o}, '0);
    repeat (2) @(negedge clk);
    check("rst_outstanding", {c_outstanding_o, outstanding_o}, '0);
    exp_q.delete(); rem_q.delete(); rdy_q.delete();
    for (int i = 0; i < NB; i++) begin
      breq_q[i].delete(); breq_id[i].delete();
      brsp_q[i].delete(); brsp_id[i].delete(); brsp_due[i].delete();
    end
    ref_mem.delete(); bank_mem.delete();
    head_id = 0; next_id = 0;
    @(negedge clk);
    rst_i = 1'b0; req_i = 1'b0;
    #1;
    check("post_rst_outstanding", {c_outstanding_o, outstanding_o}, '0);
    check("post_rst_rvalid", {c_rvalid_o, rvalid_o}, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    head_id = 0; next_id = 0; cyc = 0;
    do_reset();
    // Full-width read with unaligned low address bits.
    step(1'b1, 32'h1008, 16'hFFFF, '0, 1'b0, 1'b0);
    idle(4);
    // Sparse write touching bank 1 only, then read it back.
    step(1'b1, 32'h1010, 16'h00F0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
    idle(4);
    step(1'b1, 32'h1010, 16'hFFFF, '0, 1'b0, 1'b0);
    idle(4);
    // All-zero strobe: no bank traffic, response the next cycle.
    step(1'b1, 32'h2000, 16'h0000, '0, 1'b0, 1'b0);
    idle(3);
    // Outstanding limit: banks hold their responses.
    rsp_en = 0;
    repeat (6) step(1'b1, 32'h1000 + 32'($urandom_range(0, 255)), 16'hFFFF, '0, 1'b0, 1'b0);
    rsp_en = 1;
    repeat (6) step(1'b1, 32'h1000 + 32'($urandom_range(0, 255)), 16'h0F0F, '0, 1'b0, 1'b0);
    idle(8);
    // Bank 3 answers before bank 0 across two transactions.
    slow_bank = 0;
    step(1'b1, 32'h1040, 16'h000F, '0, 1'b0, 1'b0);
    step(1'b1, 32'h1050, 16'hF000, '0, 1'b0, 1'b0);
    idle(12);
    slow_bank = -1;
    // Randomized traffic with bank stalls and variable latency.
    gnt_pct = 60; lat_max = 4;
    repeat (500) rand_step();
    idle(30);
    // Compact addressing on the second instance, then reset mid-burst.
    gnt_pct = 100; lat_max = 3;
    step(1'b1, 32'h40, 16'hFFFF, '0, 1'b0, 1'b0);
    repeat (5) rand_step();
    do_reset();
    gnt_pct = 70;
    repeat (150) rand_step();
    idle(40);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
